serial_deinterleaver: RTL and testbench
=======================================

Name: serial_deinterleaver

Overview:
Parametrised serial-to-parallel deserializer. It collects a frame of CH*W serial bits and distributes them across CH parallel channels of W bits each. Channel mapping is runtime-selectable: interleaved (round-robin) or contiguous. It adds a bit-enable, optional frame-sync alignment, an output-valid strobe and framing-error detection. It sits between a serial line receiver and per-channel parallel consumers.

Parameters:
CH, 2, number of output channels; CH >= 1.
W, 2, bits per channel; W >= 1; CH*W >= 2.
SYNC_EN, 1, 1 = frames aligned by sof; 0 = sof ignored, free-running framing from reset.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (asserted when 0)
srl  input  1  serial data bit
srl_vld  input  1  srl is sampled only on edges where srl_vld=1
sof  input  1  start of frame; qualified by srl_vld; marks the current bit as frame bit 0
mode  input  1  0 = interleaved mapping, 1 = contiguous mapping; latched at frame bit 0
par_data  output  CH*W  channel c occupies par_data[c*W +: W]
par_vld  output  1  one-cycle strobe: par_data holds a new frame
frame_err  output  1  one-cycle strobe: partial frame discarded

Behaviour:
- Definitions: N = CH*W. Bit index k = 0..N-1 in arrival order. Counter width = max(1, clog2(N)).
- Reset (rst=0, asynchronous): par_data=0, par_vld=0, frame_err=0, count=0, staging register=0, mode latch=0. State = HUNT if SYNC_EN=1, else SHIFT.
- After reset release, the first rising edge operates normally.
- FSM states:
  - HUNT: accepted bits are discarded until an edge with srl_vld=1 and sof=1. That bit is stored as k=0 and the state moves to SHIFT with count=1.
  - SHIFT: each accepted bit is stored at index count, then count increments.
- Edges with srl_vld=0: no state change; par_vld and frame_err deassert.
- Mapping for bit k, where ch is the destination channel and pos is the bit position inside that channel:
  - mode=0 (interleaved): ch = k mod CH, pos = W-1-(k div CH).
  - mode=1 (contiguous): ch = k div W, pos = W-1-(k mod W).
  - In both modes the earliest-arriving bit of a channel lands in its MSB.
- Mode latching: mode is sampled only with bit k=0 and held for the rest of the frame. Changes mid-frame take effect at the next frame.
- Frame completion: on the edge accepting bit k=N-1:
  - The full frame, including this bit, is written to par_data on that same edge.
  - par_vld=1 for exactly the following cycle.
  - count wraps to 0 and the state stays SHIFT, so back-to-back frames need no gap.
- par_data holds its value until the next completed frame. It never shows partial data.
- Mid-frame sof (SYNC_EN=1, count != 0, srl_vld=1, sof=1):
  - The partial frame is dropped and frame_err=1 for one cycle.
  - The current bit becomes k=0 of a new frame, count=1, and mode is re-latched.
  - par_data and par_vld are unaffected.
- sof coinciding with k=N-1 is also a mid-frame sof: no par_vld, frame_err=1, and the bit restarts framing.
- sof at count=0 in SHIFT is a normal frame start, with no error.
- SYNC_EN=0: sof has no effect, frame_err is tied to 0, and framing starts at the first accepted bit after reset.
- par_vld and frame_err are never high in the same cycle.
- Reset mid-frame: the partial frame is lost, and no par_vld or frame_err is produced for it.
- N=2^m: count wraps naturally. Other N: count is explicitly cleared at N-1 and never exceeds N-1.

Test Plan:
1. CH=2, W=2, SYNC_EN=1, mode=0; sof with the first bit; serial 1,1,0,0 -> one cycle after the 4th bit, par_data=4'b1010 (ch0=10, ch1=10) and par_vld pulses for 1 cycle.
2. Same bits with mode=1 -> par_data=4'b0011 (ch0=11, ch1=00). Toggle mode mid-frame -> mapping unchanged until the next frame.
3. Bits before the first sof (0,1,1) in HUNT are discarded. Then sof+1,0,0,1 with mode=0 -> par_data=4'b0110.
4. sof after 2 bits of a frame -> frame_err pulses 1 cycle, par_data retains the prior value, and the next 4 bits starting at that sof bit form a correct frame.
5. srl_vld gaps of 0-3 idle cycles inserted randomly between bits of frame 1,0,0,1 -> same par_data=4'b0110. Back-to-back frames produce par_vld every 4 accepted bits.
6. CH=3, W=3, SYNC_EN=0, random streams vs scoreboard, count wrap at 8 checked, async rst (0) asserted mid-frame -> all outputs 0 immediately, with no spurious strobes after release.

Source files
------------

// File: rtl/serial_deinterleaver.sv
// Serial-to-parallel deserializer: gathers CH*W serial bits per frame and
// scatters them across CH channels using an interleaved or contiguous mapping.
module serial_deinterleaver #(
  parameter int CH      = 2,
  parameter int W       = 2,
  parameter int SYNC_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            srl,
  input  logic            srl_vld,
  input  logic            sof,
  input  logic            mode,
  output logic [CH*W-1:0] par_data,
  output logic            par_vld,
  output logic            frame_err
);

  localparam int N  = CH * W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [N-1:0]    stage_q, stage_d;
  logic            mode_q, mode_d;
  logic [N-1:0]    par_data_q, par_data_d;
  logic            par_vld_q, par_vld_d;
  logic            frame_err_q, frame_err_d;

  logic            start_s;
  logic            accept_s;
  logic [CW-1:0]   k_s;
  logic            eff_mode_s;
  logic [N-1:0]    frame_s;

  // Position of arrival bit k inside the flat channel vector; first bit of a channel lands in its MSB.
  function automatic logic [CW-1:0] bit_idx(input logic [CW-1:0] k, input logic m);
    int ki;
    int v;
    ki = int'(k);
    if (m) begin
      v = (ki / W) * W + (W - 1 - (ki % W));
    end else begin
      v = (ki % CH) * W + (W - 1 - (ki / CH));
    end
    return v[CW-1:0];
  endfunction

  // Next-state logic: framing, bit placement and output strobes.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    stage_d     = stage_q;
    mode_d      = mode_q;
    par_data_d  = par_data_q;
    par_vld_d   = 1'b0;
    frame_err_d = 1'b0;

    start_s    = (SYNC_EN != 0) && sof;
    accept_s   = srl_vld && ((state_q == SHIFT) || start_s);
    k_s        = start_s ? '0 : count_q;
    eff_mode_s = (k_s == '0) ? mode : mode_q;
    frame_s    = stage_q;
    frame_s[bit_idx(k_s, eff_mode_s)] = srl;

    if (accept_s) begin
      state_d = SHIFT;
      stage_d = frame_s;
      mode_d  = eff_mode_s;
      if (start_s) begin
        // A sof mid-frame (including on the last bit) abandons the partial frame.
        frame_err_d = (state_q == SHIFT) && (count_q != '0);
        count_d     = ONE;
      end else if (count_q == LAST) begin
        par_data_d = frame_s;
        par_vld_d  = 1'b1;
        count_d    = '0;
      end else begin
        count_d = count_q + ONE;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if (SYNC_EN != 0) begin
        state_q <= HUNT;
      end else begin
        state_q <= SHIFT;
      end
      count_q     <= '0;
      stage_q     <= '0;
      mode_q      <= 1'b0;
      par_data_q  <= '0;
      par_vld_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      stage_q     <= stage_d;
      mode_q      <= mode_d;
      par_data_q  <= par_data_d;
      par_vld_q   <= par_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign par_data  = par_data_q;
  assign par_vld   = par_vld_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_deinterleaver.sv
// Bench: hand-computed vector table and corner sequences for a synced 2x2
// instance, plus randomized checking of both instances against a frame model.
module tb_serial_deinterleaver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, srl_a, vld_a, sof_a, mode_a, pv_a, fe_a;
  logic [3:0] pd_a;
  logic       rst_b, srl_b, vld_b, sof_b, mode_b, pv_b, fe_b;
  logic [8:0] pd_b;

  serial_deinterleaver #(.CH(2), .W(2), .SYNC_EN(1)) u_a (
    .clk(clk), .rst(rst_a), .srl(srl_a), .srl_vld(vld_a), .sof(sof_a), .mode(mode_a),
    .par_data(pd_a), .par_vld(pv_a), .frame_err(fe_a)
  );

  serial_deinterleaver #(.CH(3), .W(3), .SYNC_EN(0)) u_b (
    .clk(clk), .rst(rst_b), .srl(srl_b), .srl_vld(vld_b), .sof(sof_b), .mode(mode_b),
    .par_data(pd_b), .par_vld(pv_b), .frame_err(fe_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level reference model: collects arrival bits, then builds each channel.
  typedef struct {
    int          cnt;
    bit          hunt;
    bit          md;
    bit [15:0]   bits;
    logic [15:0] pd;
    bit          pv;
    bit          fe;
  } mdl_t;

  function automatic mdl_t mdl_reset(input int se);
    mdl_t m;
    m.cnt = 0; m.hunt = (se != 0); m.md = 1'b0; m.bits = '0;
    m.pd = '0; m.pv = 1'b0; m.fe = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t mi, input int ch, input int w, input int se,
                                    input bit v, input bit s, input bit md, input bit b);
    mdl_t m;
    int k;
    m = mi;
    m.pv = 1'b0;
    m.fe = 1'b0;
    if (!v) return m;
    if (se != 0 && s) begin
      if (!m.hunt && m.cnt != 0) m.fe = 1'b1;
      m.hunt = 1'b0;
      m.cnt  = 0;
    end else if (m.hunt) begin
      return m;
    end
    if (m.cnt == 0) m.md = md;
    m.bits[m.cnt] = b;
    m.cnt++;
    if (m.cnt == ch * w) begin
      m.pd = '0;
      for (int c = 0; c < ch; c++) begin
        for (int j = 0; j < w; j++) begin
          k = m.md ? (c * w + j) : (j * ch + c);
          m.pd[c * w + w - 1 - j] = m.bits[k];
        end
      end
      m.pv  = 1'b1;
      m.cnt = 0;
    end
    return m;
  endfunction

  mdl_t ma, mb;

  task automatic step_a(input bit v, input bit s, input bit m, input bit b);
    vld_a = v; sof_a = s; mode_a = m; srl_a = b;
    @(posedge clk);
    #1;
    ma = mdl_step(ma, 2, 2, 1, v, s, m, b);
  endtask

  task automatic step_b(input bit v, input bit s, input bit m, input bit b);
    vld_b = v; sof_b = s; mode_b = m; srl_b = b;
    @(posedge clk);
    #1;
    mb = mdl_step(mb, 3, 3, 0, v, s, m, b);
  endtask

  task automatic cmp_a(input string nm);
    chk({nm, "_pd"}, {12'b0, pd_a}, ma.pd);
    chk({nm, "_pv"}, {15'b0, pv_a}, {15'b0, ma.pv});
    chk({nm, "_fe"}, {15'b0, fe_a}, {15'b0, ma.fe});
  endtask

  task automatic cmp_b(input string nm);
    chk({nm, "_pd"}, {7'b0, pd_b}, mb.pd);
    chk({nm, "_pv"}, {15'b0, pv_b}, {15'b0, mb.pv});
    chk({nm, "_fe"}, {15'b0, fe_b}, {15'b0, mb.fe});
  endtask

  typedef struct {
    bit       v, s, m, b;
    bit [3:0] pd;
    bit       pv, fe;
  } vec_t;

  function automatic vec_t mkv(input bit v, input bit s, input bit m, input bit b,
                               input bit [3:0] pd, input bit pv, input bit fe);
    vec_t t;
    t.v = v; t.s = s; t.m = m; t.b = b; t.pd = pd; t.pv = pv; t.fe = fe;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    bit [3:0] f;
    int guard;

    // Hand-derived vectors for the 2x2 synced instance.
    tbl.push_back(mkv(1,0,0,0, 4'h0,0,0));
    tbl.push_back(mkv(1,0,0,1, 4'h0,0,0));
    tbl.push_back(mkv(1,0,0,1, 4'h0,0,0));
    tbl.push_back(mkv(1,1,0,1, 4'h0,0,0));
    tbl.push_back(mkv(1,0,0,0, 4'h0,0,0));
    tbl.push_back(mkv(0,1,0,0, 4'h0,0,0));
    tbl.push_back(mkv(1,0,0,0, 4'h0,0,0));
    tbl.push_back(mkv(1,0,0,1, 4'h6,1,0));
    tbl.push_back(mkv(0,0,0,0, 4'h6,0,0));
    tbl.push_back(mkv(1,1,0,1, 4'h6,0,0));
    tbl.push_back(mkv(1,0,0,1, 4'h6,0,0));
    tbl.push_back(mkv(1,0,0,0, 4'h6,0,0));
    tbl.push_back(mkv(1,0,0,0, 4'hA,1,0));
    tbl.push_back(mkv(1,1,1,1, 4'hA,0,0));
    tbl.push_back(mkv(1,0,0,1, 4'hA,0,0));
    tbl.push_back(mkv(1,0,1,0, 4'hA,0,0));
    tbl.push_back(mkv(1,0,0,0, 4'h3,1,0));
    tbl.push_back(mkv(1,0,0,1, 4'h3,0,0));
    tbl.push_back(mkv(1,0,1,1, 4'h3,0,0));
    tbl.push_back(mkv(1,0,1,0, 4'h3,0,0));
    tbl.push_back(mkv(1,0,1,0, 4'hA,1,0));
    tbl.push_back(mkv(1,1,0,1, 4'hA,0,0));
    tbl.push_back(mkv(1,0,0,0, 4'hA,0,0));
    tbl.push_back(mkv(1,1,0,0, 4'hA,0,1));
    tbl.push_back(mkv(1,0,0,1, 4'hA,0,0));
    tbl.push_back(mkv(1,0,0,1, 4'hA,0,0));
    tbl.push_back(mkv(1,0,0,0, 4'h9,1,0));
    tbl.push_back(mkv(1,1,1,1, 4'h9,0,0));
    tbl.push_back(mkv(1,0,1,1, 4'h9,0,0));
    tbl.push_back(mkv(1,0,1,0, 4'h9,0,0));
    tbl.push_back(mkv(1,1,0,1, 4'h9,0,1));
    tbl.push_back(mkv(1,0,0,0, 4'h9,0,0));
    tbl.push_back(mkv(1,0,0,0, 4'h9,0,0));
    tbl.push_back(mkv(1,0,0,1, 4'h6,1,0));
    tbl.push_back(mkv(0,0,0,0, 4'h6,0,0));

    rst_a = 1'b0; rst_b = 1'b0;
    vld_a = 1'b0; sof_a = 1'b0; mode_a = 1'b0; srl_a = 1'b0;
    vld_b = 1'b0; sof_b = 1'b0; mode_b = 1'b0; srl_b = 1'b0;
    ma = mdl_reset(1);
    mb = mdl_reset(0);
    repeat (2) @(posedge clk);
    #1;
    cmp_a("rst_a");
    cmp_b("rst_b");
    rst_a = 1'b1; rst_b = 1'b1;

    foreach (tbl[i]) begin
      step_a(tbl[i].v, tbl[i].s, tbl[i].m, tbl[i].b);
      chk($sformatf("tbl%0d_pd", i), {12'b0, pd_a}, {12'b0, tbl[i].pd});
      chk($sformatf("tbl%0d_pv", i), {15'b0, pv_a}, {15'b0, tbl[i].pv});
      chk($sformatf("tbl%0d_fe", i), {15'b0, fe_a}, {15'b0, tbl[i].fe});
    end

    // Frame 1,0,0,1 with random idle gaps between accepted bits.
    f = 4'b1001;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        step_a(1'b1, i == 0, 1'b0, f[3 - i]);
        chk("gap_pv", {15'b0, pv_a}, {15'b0, (i == 3)});
        if (i < 3) begin
          for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
            step_a(1'b0, 1'b0, 1'b0, 1'b1);
            chk("gap_idle_pv", {15'b0, pv_a}, 16'h0);
          end
        end
      end
      chk("gap_pd", {12'b0, pd_a}, 16'h6);
    end

    // Random streams on the synced instance, with occasional sof.
    for (int i = 0; i < 400; i++) begin
      step_a($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cmp_a("rnd_a");
      chk("excl_a", {15'b0, pv_a & fe_a}, 16'h0);
    end
    vld_a = 1'b0;

    // Free-running 3x3 instance: deterministic wrap frames, then random.
    for (int i = 0; i < 9; i++) step_b(1'b1, 1'b0, 1'b0, i == 0);
    chk("b_m0_pd", {7'b0, pd_b}, 16'h004);
    chk("b_m0_pv", {15'b0, pv_b}, 16'h1);
    for (int i = 0; i < 9; i++) step_b(1'b1, 1'b1, 1'b1, i == 8);
    chk("b_m1_pd", {7'b0, pd_b}, 16'h040);
    chk("b_m1_pv", {15'b0, pv_b}, 16'h1);
    for (int i = 0; i < 500; i++) begin
      step_b($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cmp_b("rnd_b");
    end

    // Asynchronous reset in the middle of a frame.
    guard = 0;
    while ((mb.cnt == 0 || mb.pd == 16'h0) && guard < 40) begin
      step_b(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      guard++;
    end
    chk("b_midframe_setup", {15'b0, (mb.cnt != 0 && mb.pd != 16'h0)}, 16'h1);
    step_b(1'b1, 1'b0, 1'b0, 1'b1);
    #3;
    rst_b = 1'b0;
    #1;
    mb = mdl_reset(0);
    cmp_b("b_async_rst");
    @(posedge clk);
    #3;
    rst_b = 1'b1;
    vld_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_b(1'b0, 1'b0, 1'b0, 1'b0);
      cmp_b("b_post_rst");
    end
    for (int i = 0; i < 200; i++) begin
      step_b($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cmp_b("rnd_b2");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
